// File: rtl/dht_lcd_formatter.sv
// Formats one DHT reading into PCF8574-encoded HD44780 byte streams
// and hands each finished frame to the I2C LCD driver.
module dht_lcd_formatter #(
  parameter int         BACKLIGHT = 1,
  parameter logic [7:0] TEMP_UNIT = 8'h43
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dht_valid,
  input  logic [7:0]   dht_hum_int,
  input  logic [7:0]   dht_hum_dec,
  input  logic [7:0]   dht_temp_int,
  input  logic [7:0]   dht_temp_dec,
  input  logic         lcd_done,
  output logic [63:0]  lcd_init_bytes,
  output logic [255:0] lcd_line1_bytes,
  output logic [15:0]  lcd_line2_cmd,
  output logic [255:0] lcd_line2_bytes,
  output logic [7:0]   project_step,
  output logic         busy,
  output logic         sat_flag
);

  localparam logic BL = (BACKLIGHT != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_BUILD = 3'd2;
  localparam logic [2:0] S_PUB   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_REL   = 3'd5;

  localparam logic [7:0] STEP_HOLD = 8'd1;
  localparam logic [7:0] STEP_SEND = 8'd3;

  function automatic logic [15:0] enc(
    input logic [7:0] c,
    input logic       rs
  );
    return {c[7:4], BL, 1'b1, 1'b0, rs,
            c[3:0], BL, 1'b1, 1'b0, rs};
  endfunction

  function automatic logic [7:0] digit(
    input logic [3:0] d
  );
    return {4'h3, d};
  endfunction

  function automatic logic [6:0] sat_int(
    input logic [7:0] v
  );
    return (v > 8'd99) ? 7'd99 : v[6:0];
  endfunction

  function automatic logic [3:0] sat_dec(
    input logic [7:0] v
  );
    return (v > 8'd9) ? 4'd9 : v[3:0];
  endfunction

  // idx 0..15 is line 1 (humidity), 16..31 is line 2 (temperature)
  function automatic logic [7:0] char_at(
    input logic [4:0] idx,
    input logic [3:0] tens_h,
    input logic [3:0] unit_h,
    input logic [3:0] dec_h,
    input logic [3:0] tens_t,
    input logic [3:0] unit_t,
    input logic [3:0] dec_t
  );
    logic       l2;
    logic [3:0] tn;
    logic [3:0] un;
    logic [3:0] dc;
    logic [7:0] c;
    l2 = idx[4];
    tn = l2 ? tens_t : tens_h;
    un = l2 ? unit_t : unit_h;
    dc = l2 ? dec_t : dec_h;
    case (idx[3:0])
      4'd0:    c = l2 ? "T" : "H";
      4'd1:    c = l2 ? "e" : "u";
      4'd2:    c = "m";
      4'd3:    c = l2 ? "p" : "i";
      4'd4:    c = ":";
      4'd6:    c = (tn == 4'd0) ? " " : digit(tn);
      4'd7:    c = digit(un);
      4'd8:    c = ".";
      4'd9:    c = digit(dc);
      4'd11:   c = l2 ? TEMP_UNIT : "%";
      default: c = " ";
    endcase
    return c;
  endfunction

  localparam logic [15:0]  ENC_SP = enc(8'h20, 1'b1);
  localparam logic [255:0] SPACES = {16{ENC_SP}};

  assign lcd_init_bytes = {enc(8'h02, 1'b0), enc(8'h28, 1'b0),
                           enc(8'h0C, 1'b0), enc(8'h80, 1'b0)};
  assign lcd_line2_cmd  = enc(8'hC0, 1'b0);

  logic [2:0]   state_q, state_d;
  logic [7:0]   step_q, step_d;
  logic         sat_q, sat_d;
  logic         sat_pend_q, sat_pend_d;
  logic         pend_v_q, pend_v_d;
  logic [31:0]  pend_q, pend_d;
  logic [6:0]   hum_v_q, hum_v_d;
  logic [6:0]   temp_v_q, temp_v_d;
  logic [3:0]   hum_t_q, hum_t_d;
  logic [3:0]   temp_t_q, temp_t_d;
  logic [3:0]   hum_dc_q, hum_dc_d;
  logic [3:0]   temp_dc_q, temp_dc_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [511:0] shadow_q, shadow_d;
  logic [255:0] line1_q, line1_d;
  logic [255:0] line2_q, line2_d;

  logic [31:0]  sample;
  logic [31:0]  src;

  assign sample = {dht_hum_int, dht_hum_dec,
                   dht_temp_int, dht_temp_dec};
  assign src    = dht_valid ? sample : pend_q;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    sat_d      = sat_q;
    sat_pend_d = sat_pend_q;
    pend_v_d   = pend_v_q;
    pend_d     = pend_q;
    hum_v_d    = hum_v_q;
    temp_v_d   = temp_v_q;
    hum_t_d    = hum_t_q;
    temp_t_d   = temp_t_q;
    hum_dc_d   = hum_dc_q;
    temp_dc_d  = temp_dc_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    line1_d    = line1_q;
    line2_d    = line2_q;

    if (dht_valid && state_q != S_IDLE) begin
      pend_v_d = 1'b1;
      pend_d   = sample;
    end

    case (state_q)
      S_IDLE: begin
        if (dht_valid || pend_v_q) begin
          pend_v_d   = 1'b0;
          hum_v_d    = sat_int(src[31:24]);
          hum_dc_d   = sat_dec(src[23:16]);
          temp_v_d   = sat_int(src[15:8]);
          temp_dc_d  = sat_dec(src[7:0]);
          sat_pend_d = (src[31:24] > 8'd99) ||
                       (src[23:16] > 8'd9) ||
                       (src[15:8] > 8'd99) ||
                       (src[7:0] > 8'd9);
          hum_t_d    = 4'd0;
          temp_t_d   = 4'd0;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        if (hum_v_q < 7'd10 && temp_v_q < 7'd10) begin
          cnt_d   = 5'd0;
          state_d = S_BUILD;
        end else begin
          if (hum_v_q >= 7'd10) begin
            hum_v_d = hum_v_q - 7'd10;
            hum_t_d = hum_t_q + 4'd1;
          end
          if (temp_v_q >= 7'd10) begin
            temp_v_d = temp_v_q - 7'd10;
            temp_t_d = temp_t_q + 4'd1;
          end
        end
      end
      S_BUILD: begin
        shadow_d = {shadow_q[495:0],
                    enc(char_at(cnt_q,
                                hum_t_q, hum_v_q[3:0], hum_dc_q,
                                temp_t_q, temp_v_q[3:0], temp_dc_q),
                        1'b1)};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_PUB;
      end
      S_PUB: begin
        line1_d = shadow_q[511:256];
        line2_d = shadow_q[255:0];
        sat_d   = sat_pend_q;
        step_d  = STEP_SEND;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lcd_done) begin
          step_d  = STEP_HOLD;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (!lcd_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= STEP_HOLD;
      sat_q      <= 1'b0;
      sat_pend_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_q     <= '0;
      hum_v_q    <= '0;
      temp_v_q   <= '0;
      hum_t_q    <= '0;
      temp_t_q   <= '0;
      hum_dc_q   <= '0;
      temp_dc_q  <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      line1_q    <= SPACES;
      line2_q    <= SPACES;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      sat_q      <= sat_d;
      sat_pend_q <= sat_pend_d;
      pend_v_q   <= pend_v_d;
      pend_q     <= pend_d;
      hum_v_q    <= hum_v_d;
      temp_v_q   <= temp_v_d;
      hum_t_q    <= hum_t_d;
      temp_t_q   <= temp_t_d;
      hum_dc_q   <= hum_dc_d;
      temp_dc_q  <= temp_dc_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      line1_q    <= line1_d;
      line2_q    <= line2_d;
    end
  end

  assign lcd_line1_bytes = line1_q;
  assign lcd_line2_bytes = line2_q;
  assign project_step    = step_q;
  assign busy            = (state_q != S_IDLE);
  assign sat_flag        = sat_q;

endmodule
